soc_test_harness: RTL and testbench
===================================

# soc_test_harness

Self-checking simulation/FPGA harness controller placed between the board-level clock/reset and an `accellant_soc_*` instance. It generates the SoC's synchronous active-high reset, enforces a run budget in clock cycles, and decodes the SoC's UART output to log bytes and detect pass/fail codes. It optionally drives byte stimulus into the SoC's UART input. It replaces hand-written reset/timeout/idle-line logic in per-SoC testbenches with one parametrised block.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: clk frequency.
- `BAUD`, 115_200: UART bit rate. `DIV = CLK_FREQ_HZ / BAUD` (truncated). `DIV` must be ≥ 4.
- `RST_CYCLES`, 10: cycles `soc_rst` is held high after `rst` deasserts. Must be ≥ 1.
- `TIMEOUT_CYCLES`, 5_000_000: run budget. Must be ≥ 1.
- `CNT_W`, 32: width of `cycle_count`.
- `PASS_CODE`, 8'h50: received byte that ends the test as pass.
- `FAIL_CODE`, 8'h46: received byte that ends the test as fail.
- `LED_COUNT`, 4: width of the LED snapshot.

Ports:
- `clk`  in  1  harness and SoC clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `soc_rst`  out  1  synchronous active-high reset to the SoC.
- `soc_led`  in  LED_COUNT  SoC LED outputs.
- `soc_uart_out`  in  1  serial line driven by the SoC.
- `soc_uart_in`  out  1  serial line into the SoC; idle high.
- `stim_valid`  in  1  stimulus byte offered.
- `stim_data`  in  8  stimulus byte.
- `stim_ready`  out  1  stimulus accepted when `stim_valid && stim_ready`.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` holds a good byte.
- `rx_data`  out  8  last received byte.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `cycle_count`  out  CNT_W  cycles spent in RUN. Saturates at all-ones.
- `led_snap`  out  LED_COUNT  `soc_led` captured on entry to a terminal state.
- `done`  out  1  sticky; test ended.
- `status`  out  2  0 = running, 1 = pass, 2 = fail, 3 = timeout.

## Operation
- State machine: RESET → RUN → {PASS, FAIL, TIMEOUT}. Terminal states are sticky until `rst` is asserted.
- **RESET:** `soc_rst` = 1. A counter runs for RST_CYCLES cycles, then the block moves to RUN. `soc_rst` goes 0 on the first RUN cycle.
- **RUN:** `cycle_count` increments every cycle.
  - Reaching `TIMEOUT_CYCLES` moves the block to TIMEOUT.
  - A good byte equal to PASS_CODE moves it to PASS; FAIL_CODE moves it to FAIL.
  - Any other byte is only logged.
- **Terminal states:** `done` = 1 and `status` is set. `led_snap` is captured on the transition cycle. `cycle_count` freezes. `soc_rst` stays 0 and the RX logger keeps running.
- **Simultaneous events:** a code byte and the timeout in the same cycle resolve as PASS/FAIL; the code wins. Bytes arriving during RESET are logged but never change state.
- **RX path:**
  - `soc_uart_out` passes through a 2-flop synchronizer (reset value 1).
  - A falling edge while idle starts a frame. The line is resampled at DIV/2: if it is high, the start is treated as a glitch and RX returns to idle.
  - 8 data bits are sampled LSB first, every DIV cycles.
  - Stop bit sampled DIV later. Stop = 1 → `rx_valid` pulse. Stop = 0 → `frame_err` pulse and the byte is discarded (`rx_data` unchanged).
  - RX then waits for the line to be high before arming for the next frame.
- **Mid-operation reset:** asserting `rst` at any time aborts RX/TX frames and returns every register to its reset value.

## Timing
- **Reset values:** `soc_rst` = 1, `soc_uart_in` = 1, `stim_ready` = 0, `rx_valid` = 0, `rx_data` = 0, `frame_err` = 0, `cycle_count` = 0, `led_snap` = 0, `done` = 0, `status` = 0.
- `soc_rst` is high for exactly RST_CYCLES rising edges after the first edge with `rst` high.
- TIMEOUT is entered on the edge where `cycle_count` would become TIMEOUT_CYCLES. On that edge `done` rises and `cycle_count` reads TIMEOUT_CYCLES.
- `rx_valid` fires 3 + DIV/2 + 9·DIV cycles (±1) after the start-bit falling edge on `soc_uart_out`.
- For a PASS/FAIL code byte, `done` and `status` update on the same edge as `rx_valid`.
- All outputs are registered.

## Configuration
- `HARNESS_UART_STIM_EN` defined:
  - An 8N1 transmitter drives `soc_uart_in`, one bit every DIV cycles.
  - `stim_ready` = 1 only in RUN with the transmitter idle.
  - The handshake loads the byte; the start bit appears on the next edge; the frame lasts 10·DIV cycles.
- Not defined: `soc_uart_in` is tied to 1, `stim_ready` is tied to 0, and `stim_valid`/`stim_data` are ignored.

## Test plan
All scenarios use `CLK_FREQ_HZ` = 1_000_000 and `BAUD` = 100_000 (DIV = 10).
- **Reset sequence:** release `rst` with RST_CYCLES = 10 → `soc_rst` high for 10 edges, then 0; `cycle_count` counts from 0.
- **Timeout:** TIMEOUT_CYCLES = 200, line idle → on the 200th RUN edge `done` = 1, `status` = 3, `cycle_count` = 200 and it stays 200.
- **Log then pass:** drive 0x41 then 0x50 on `soc_uart_out` → `rx_valid` with `rx_data` = 0x41 (status stays 0), then `status` = 1. `led_snap` equals `soc_led` = 4'hA, held at the pass edge.
- **Framing error and glitch:** send 0x46 with stop = 0 → `frame_err` pulse, no FAIL. A 3-cycle low glitch → no `rx_valid`, no `frame_err`.
- **Race:** a 0x46 stop-bit sample coinciding with the timeout edge → `status` = 2.
- **With HARNESS_UART_STIM_EN:** handshake 0xA5 → `soc_uart_in` carries 0,1,0,1,0,0,1,0,1,1 at 10-cycle spacing; `stim_ready` is low during the frame.

Source files
------------

// File: rtl/soc_test_harness.sv
// soc_test_harness: SoC reset sequencer, run-budget timer and UART pass/fail decoder.
// Define HARNESS_UART_STIM_EN to add an 8N1 stimulus transmitter on soc_uart_in.
module soc_test_harness #(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned RST_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter logic [7:0]  PASS_CODE      = 8'h50,
  parameter logic [7:0]  FAIL_CODE      = 8'h46,
  parameter int unsigned LED_COUNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 soc_rst,
  input  logic [LED_COUNT-1:0] soc_led,
  input  logic                 soc_uart_out,
  output logic                 soc_uart_in,
  input  logic                 stim_valid,
  input  logic [7:0]           stim_data,
  output logic                 stim_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [LED_COUNT-1:0] led_snap,
  output logic                 done,
  output logic [1:0]           status
);
  localparam int unsigned DIV  = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned BW   = $clog2(DIV + 1);
  localparam int unsigned RW   = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {S_RESET, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  state_t           state, state_n;
  logic [RW-1:0]    rst_cnt, rst_cnt_n;
  logic [CNT_W-1:0] cycle_n;
  logic             soc_rst_n, done_n;
  logic [1:0]       status_n;

  logic [1:0]       sync;
  logic             rx_line;
  rx_state_t        rx_state, rx_state_n;
  logic [BW-1:0]    rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_good_c, rx_ferr_c;

  assign rx_line = sync[1];

  // Harness state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_RESET;
      rst_cnt <= '0;
    end else begin
      state   <= state_n;
      rst_cnt <= rst_cnt_n;
    end
  end

  // Harness next state; a code byte outranks the timeout in the same cycle
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    cycle_n   = cycle_count;
    case (state)
      S_RESET: begin
        if (rst_cnt == RW'(RST_CYCLES - 1)) state_n = S_RUN;
        else rst_cnt_n = rst_cnt + RW'(1);
      end
      S_RUN: begin
        if (cycle_count != '1) cycle_n = cycle_count + CNT_W'(1);
        if (rx_good_c && rx_shift == PASS_CODE)              state_n = S_PASS;
        else if (rx_good_c && rx_shift == FAIL_CODE)         state_n = S_FAIL;
        else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1))  state_n = S_TIMEOUT;
      end
      default: ;
    endcase
    soc_rst_n = (state_n == S_RESET);
    done_n    = 1'b0;
    status_n  = 2'd0;
    case (state_n)
      S_PASS:    begin done_n = 1'b1; status_n = 2'd1; end
      S_FAIL:    begin done_n = 1'b1; status_n = 2'd2; end
      S_TIMEOUT: begin done_n = 1'b1; status_n = 2'd3; end
      default: ;
    endcase
  end

  // Harness outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      soc_rst     <= 1'b1;
      cycle_count <= '0;
      led_snap    <= '0;
      done        <= 1'b0;
      status      <= 2'd0;
    end else begin
      soc_rst     <= soc_rst_n;
      cycle_count <= cycle_n;
      done        <= done_n;
      status      <= status_n;
      if (state == S_RUN && state_n != S_RUN) led_snap <= soc_led;
    end
  end

  // RX synchronizer, framer state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= 2'b11;
      rx_state  <= R_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], soc_uart_out};
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_valid  <= rx_good_c;
      frame_err <= rx_ferr_c;
      if (rx_good_c) rx_data <= rx_shift;
    end
  end

  // RX next state: mid-bit sampling, glitch reject on start, wait for idle after stop
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + BW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_line) rx_state_n = R_START;
      end
      R_START: begin
        if (rx_cnt == BW'(HALF - 1)) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_line ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == BW'(DIV - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_line, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt == BW'(DIV - 1)) begin
          rx_cnt_n   = '0;
          rx_good_c  = rx_line;
          rx_ferr_c  = !rx_line;
          rx_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        rx_cnt_n = '0;
        if (rx_line) rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

`ifdef HARNESS_UART_STIM_EN
  logic          tx_busy, tx_busy_n;
  logic [BW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]    tx_bit, tx_bit_n;
  logic [9:0]    tx_frame, tx_frame_n;
  logic          tx_line_n, ready_n;

  // TX state and line/ready outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy     <= 1'b0;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_frame    <= '1;
      soc_uart_in <= 1'b1;
      stim_ready  <= 1'b0;
    end else begin
      tx_busy     <= tx_busy_n;
      tx_cnt      <= tx_cnt_n;
      tx_bit      <= tx_bit_n;
      tx_frame    <= tx_frame_n;
      soc_uart_in <= tx_line_n;
      stim_ready  <= ready_n;
    end
  end

  // TX next state: frame bit 0 is always the bit currently on the line
  always_comb begin
    tx_busy_n  = tx_busy;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_frame_n = tx_frame;
    tx_line_n  = soc_uart_in;
    if (!tx_busy) begin
      if (stim_valid && stim_ready) begin
        tx_busy_n  = 1'b1;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_frame_n = {1'b1, stim_data, 1'b0};
        tx_line_n  = 1'b0;
      end
    end else if (tx_cnt == BW'(DIV - 1)) begin
      tx_cnt_n = '0;
      if (tx_bit == 4'd9) begin
        tx_busy_n = 1'b0;
        tx_line_n = 1'b1;
      end else begin
        tx_bit_n   = tx_bit + 4'd1;
        tx_frame_n = {1'b1, tx_frame[9:1]};
        tx_line_n  = tx_frame[1];
      end
    end else begin
      tx_cnt_n = tx_cnt + BW'(1);
    end
    ready_n = (state_n == S_RUN) && !tx_busy_n;
  end
`else
  logic unused_stim;
  assign unused_stim = ^{stim_valid, stim_data};
  assign soc_uart_in = 1'b1;
  assign stim_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_soc_test_harness.sv
// Bench for soc_test_harness: DIV = 10, RST_CYCLES = 10, TIMEOUT_CYCLES = 200.
// RX events are checked by a scoreboard monitor fed from the stimulus sequence.
module tb_soc_test_harness;
  localparam int DIV = 10;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    logic [1:0] status;
    int         at_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        soc_rst;
  logic [3:0]  soc_led = 4'h0;
  logic        uart_out = 1'b1;
  logic        soc_uart_in;
  logic        stim_valid = 1'b0;
  logic [7:0]  stim_data = 8'h00;
  logic        stim_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        frame_err;
  logic [31:0] cycle_count;
  logic [3:0]  led_snap;
  logic        done;
  logic [1:0]  status;

  int   checks = 0;
  int   failures = 0;
  int   cyc;
  exp_t exp_q[$];

  soc_test_harness #(
    .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .RST_CYCLES(10),
    .TIMEOUT_CYCLES(200), .CNT_W(32), .PASS_CODE(8'h50),
    .FAIL_CODE(8'h46), .LED_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .soc_rst(soc_rst), .soc_led(soc_led),
    .soc_uart_out(uart_out), .soc_uart_in(soc_uart_in),
    .stim_valid(stim_valid), .stim_data(stim_data), .stim_ready(stim_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err),
    .cycle_count(cycle_count), .led_snap(led_snap), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  // Number of rising edges since rst was released
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int k);
    int guard = 0;
    while (cyc < k) begin
      @(negedge clk);
      guard++;
      if (guard > 10000) begin
        checks++;
        failures++;
        $display("FAIL go_to: cyc=%0d never reached %0d", cyc, k);
        return;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (rx_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: valid=%0b ferr=%0b data=0x%0h at cyc %0d, expected no event",
                   rx_valid, frame_err, rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rx_frame_err", frame_err, e.ferr);
          check("rx_valid", rx_valid, !e.ferr);
          check("rx_data", rx_data, e.data);
          check("rx_status", status, e.status);
          check("rx_done", done, e.status != 2'd0);
          checks++;
          if (cyc < e.at_edge - 1 || cyc > e.at_edge + 1) begin
            failures++;
            $display("FAIL rx_latency: event at cyc %0d expected %0d +/-1", cyc, e.at_edge);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    uart_out = 1'b1;
    stim_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_soc_rst", soc_rst, 1'b1);
    check("rst_uart_in", soc_uart_in, 1'b1);
    check("rst_stim_ready", stim_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_led_snap", led_snap, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'd0);
    rst = 1'b1;
  endtask

  // Drive one 8N1 frame, each bit held DIV cycles, starting at the current negedge
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_out = f[i];
      repeat (DIV) @(negedge clk);
    end
    uart_out = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a5_frame;
    a5_frame = 10'b11_0100_1010;
    fork monitor(); join_none

    // Reset sequence and timeout
    do_reset();
    go_to(9);
    check("soc_rst_edge9", soc_rst, 1'b1);
    go_to(10);
    check("soc_rst_edge10", soc_rst, 1'b0);
    check("count_first_run", cycle_count, 32'd0);
    go_to(11);
    check("count_second_run", cycle_count, 32'd1);
`ifndef HARNESS_UART_STIM_EN
    stim_valid = 1'b1;
    stim_data = 8'h55;
`endif
    go_to(209);
    check("pre_timeout_done", done, 1'b0);
    check("pre_timeout_count", cycle_count, 32'd199);
    go_to(210);
    check("timeout_done", done, 1'b1);
    check("timeout_status", status, 2'd3);
    check("timeout_count", cycle_count, 32'd200);
    go_to(240);
    check("timeout_count_frozen", cycle_count, 32'd200);
    check("timeout_soc_rst", soc_rst, 1'b0);
`ifndef HARNESS_UART_STIM_EN
    check("no_stim_uart_in", soc_uart_in, 1'b1);
    check("no_stim_ready", stim_ready, 1'b0);
`endif

    // Log 0x41, then pass on 0x50
    soc_led = 4'hA;
    do_reset();
    go_to(10);
    exp_q.push_back('{ferr: 1'b0, data: 8'h41, status: 2'd0, at_edge: cyc + 98});
    send_frame(8'h41, 1'b1);
    exp_q.push_back('{ferr: 1'b0, data: 8'h50, status: 2'd1, at_edge: cyc + 98});
    send_frame(8'h50, 1'b1);
    check("pass_status", status, 2'd1);
    check("pass_led_snap", led_snap, 4'hA);
    soc_led = 4'h5;
    go_to(230);
    check("pass_led_held", led_snap, 4'hA);
    check("pass_status_sticky", status, 2'd1);
    check("pass_count_frozen", cycle_count, 32'd198);
    check("pass_queue_empty", exp_q.size(), 0);

    // Framing error on 0x46, then a short glitch
    do_reset();
    go_to(10);
    exp_q.push_back('{ferr: 1'b1, data: 8'h00, status: 2'd0, at_edge: cyc + 98});
    send_frame(8'h46, 1'b0);
    go_to(120);
    uart_out = 1'b0;
    repeat (3) @(negedge clk);
    uart_out = 1'b1;
    go_to(200);
    check("ferr_no_fail_status", status, 2'd0);
    check("ferr_no_fail_done", done, 1'b0);
    check("ferr_queue_empty", exp_q.size(), 0);
    go_to(211);
    check("ferr_then_timeout", status, 2'd3);

    // 0x46 stop sample on the timeout edge
    do_reset();
    go_to(112);
    exp_q.push_back('{ferr: 1'b0, data: 8'h46, status: 2'd2, at_edge: cyc + 98});
    send_frame(8'h46, 1'b1);
    check("race_status", status, 2'd2);
    check("race_done", done, 1'b1);

    // Reset in the middle of an incoming frame
    uart_out = 1'b0;
    repeat (30) @(negedge clk);
    do_reset();
    go_to(130);
    check("abort_status", status, 2'd0);
    check("abort_queue_empty", exp_q.size(), 0);

`ifdef HARNESS_UART_STIM_EN
    // Stimulus transmitter frame for 0xA5
    do_reset();
    go_to(11);
    check("stim_ready_run", stim_ready, 1'b1);
    check("stim_line_idle", soc_uart_in, 1'b1);
    go_to(12);
    stim_valid = 1'b1;
    stim_data = 8'hA5;
    go_to(13);
    stim_valid = 1'b0;
    check("stim_ready_busy", stim_ready, 1'b0);
    for (int k = 0; k < 10; k++) begin
      go_to(13 + 10 * k + 5);
      check($sformatf("stim_bit%0d", k), soc_uart_in, a5_frame[k]);
    end
    go_to(115);
    check("stim_ready_after", stim_ready, 1'b1);
    check("stim_line_after", soc_uart_in, 1'b1);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
